// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: exception bit indices, mcause
// codes, stall patterns and the decoded-exception record.
package pipe_ctrl_pkg;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam int EXC_W             = 7;
    localparam int EXC_INST_MISALIGN = 0;
    localparam int EXC_ILLEGAL       = 1;
    localparam int EXC_EBREAK        = 2;
    localparam int EXC_LOAD_MISALIGN = 3;
    localparam int EXC_STORE_MISALIGN = 4;
    localparam int EXC_ECALL         = 5;
    localparam int EXC_MRET          = 6;

    localparam logic [31:0] CAUSE_INST_MISALIGN  = 32'd0;
    localparam logic [31:0] CAUSE_ILLEGAL        = 32'd2;
    localparam logic [31:0] CAUSE_EBREAK         = 32'd3;
    localparam logic [31:0] CAUSE_LOAD_MISALIGN  = 32'd4;
    localparam logic [31:0] CAUSE_STORE_MISALIGN = 32'd6;
    localparam logic [31:0] CAUSE_ECALL          = 32'd11;

    // Bit k set = stage k held; a stalling stage also holds every older stage.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        TVAL_ZERO = 2'd0,
        TVAL_INST = 2'd1,
        TVAL_PC   = 2'd2
    } tval_sel_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] cause;
        logic        is_mret;
        tval_sel_e   tval_sel;
    } exc_dec_t;

endpackage

// File: rtl/pipe_ctrl_exc_prio_enc.sv
// Priority encoder for the mem-stage exception vector; the lowest set bit wins
// and selects the mcause code plus where mtval comes from.
module exc_prio_enc
    import pipe_ctrl_pkg::*;
(
    input  logic [EXC_W-1:0] exc_i,
    output exc_dec_t         dec_o
);

    always_comb begin
        dec_o       = '0;
        dec_o.valid = |exc_i;
        if (exc_i[EXC_INST_MISALIGN]) begin
            dec_o.cause    = CAUSE_INST_MISALIGN;
            dec_o.tval_sel = TVAL_PC;
        end else if (exc_i[EXC_ILLEGAL]) begin
            dec_o.cause    = CAUSE_ILLEGAL;
            dec_o.tval_sel = TVAL_INST;
        end else if (exc_i[EXC_EBREAK]) begin
            dec_o.cause    = CAUSE_EBREAK;
        end else if (exc_i[EXC_LOAD_MISALIGN]) begin
            dec_o.cause    = CAUSE_LOAD_MISALIGN;
            dec_o.tval_sel = TVAL_PC;
        end else if (exc_i[EXC_STORE_MISALIGN]) begin
            dec_o.cause    = CAUSE_STORE_MISALIGN;
            dec_o.tval_sel = TVAL_PC;
        end else if (exc_i[EXC_ECALL]) begin
            dec_o.cause    = CAUSE_ECALL;
        end else if (exc_i[EXC_MRET]) begin
            dec_o.is_mret  = 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall merge, 2-cycle trap/mret entry, pc redirect arbitration.
// Define PIPE_CTRL_PERF_CNT_EN to add stall-cycle and trap performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic        stallreq_if_i,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic        branch_redirect_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] exception_i,
    input  logic [31:0] exception_pc_i,
    input  logic [31:0] exception_inst_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic        branch_kill_o,
    output logic        redirect_o,
    output logic [31:0] new_pc_o,
    output logic        trap_we_o,
    output logic [31:0] trap_cause_o,
    output logic [31:0] trap_epc_o,
    output logic [31:0] trap_tval_o,
    output logic        mret_o
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_trap_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_TRAP_HOLD = 2'd1,
        S_TRAP_FIRE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] tval_q, tval_d;
    logic        mret_q, mret_d;
    exc_dec_t    exc_dec;

    // Only bits 0..6 carry defined exceptions; mtvec low bits are forced to zero.
    logic unused_inputs;
    assign unused_inputs = ^{exception_i[31:EXC_W], mtvec_i[1:0]};

    exc_prio_enc u_exc_prio_enc (
        .exc_i (exception_i[EXC_W-1:0]),
        .dec_o (exc_dec)
    );

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q <= S_RUN;
            cause_q <= '0;
            epc_q   <= '0;
            tval_q  <= '0;
            mret_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            tval_q  <= tval_d;
            mret_q  <= mret_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cause_d       = cause_q;
        epc_d         = epc_q;
        tval_d        = tval_q;
        mret_d        = mret_q;
        stall_o       = STALL_NONE;
        flush_o       = 1'b0;
        branch_kill_o = 1'b0;
        redirect_o    = 1'b0;
        new_pc_o      = RESET_PC;
        trap_we_o     = 1'b0;
        trap_cause_o  = '0;
        trap_epc_o    = '0;
        trap_tval_o   = '0;
        mret_o        = 1'b0;

        unique case (state_q)
            S_RUN: begin
                if (stallreq_mem_i)     stall_o = STALL_MEM;
                else if (stallreq_ex_i) stall_o = STALL_EX;
                else if (stallreq_id_i) stall_o = STALL_ID;
                else if (stallreq_if_i) stall_o = STALL_IF;

                // A pending exception is older than the ex-stage branch, so it
                // always drops the redirect; it is taken once mem is not busy.
                if (exc_dec.valid) begin
                    if (!stallreq_mem_i) begin
                        cause_d = exc_dec.cause;
                        epc_d   = exception_pc_i;
                        mret_d  = exc_dec.is_mret;
                        unique case (exc_dec.tval_sel)
                            TVAL_INST: tval_d = exception_inst_i;
                            TVAL_PC:   tval_d = exception_pc_i;
                            default:   tval_d = '0;
                        endcase
                        state_d = S_TRAP_HOLD;
                    end
                end else if (branch_redirect_i && !stallreq_ex_i && !stallreq_mem_i) begin
                    redirect_o    = 1'b1;
                    branch_kill_o = 1'b1;
                    new_pc_o      = branch_target_i;
                    stall_o[1]    = NoStop;
                end
            end
            S_TRAP_HOLD: begin
                stall_o = STALL_MEM;
                state_d = S_TRAP_FIRE;
            end
            S_TRAP_FIRE: begin
                flush_o    = 1'b1;
                redirect_o = 1'b1;
                if (mret_q) begin
                    new_pc_o = mepc_i;
                    mret_o   = 1'b1;
                end else begin
                    new_pc_o     = {mtvec_i[31:2], 2'b00};
                    trap_we_o    = 1'b1;
                    trap_cause_o = cause_q;
                    trap_epc_o   = epc_q;
                    trap_tval_o  = tval_q;
                end
                state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_trap_q;

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            perf_stall_q <= '0;
            perf_trap_q  <= '0;
        end else begin
            if (|stall_o) perf_stall_q <= perf_stall_q + 32'd1;
            if (trap_we_o) perf_trap_q <= perf_trap_q + 32'd1;
        end
    end

    assign perf_stall_cnt_o = perf_stall_q;
    assign perf_trap_cnt_o  = perf_trap_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl with hand-computed expectations.
module tb_pipe_ctrl;

    logic        clk_i = 1'b0;
    logic        n_rst_i;
    logic        stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
    logic        branch_redirect_i;
    logic [31:0] branch_target_i, exception_i, exception_pc_i, exception_inst_i;
    logic [31:0] mtvec_i, mepc_i;
    logic [5:0]  stall_o;
    logic        flush_o, branch_kill_o, redirect_o, trap_we_o, mret_o;
    logic [31:0] new_pc_o, trap_cause_o, trap_epc_o, trap_tval_o;
`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] perf_stall_cnt_o, perf_trap_cnt_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    pipe_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i             (clk_i),
        .n_rst_i           (n_rst_i),
        .stallreq_if_i     (stallreq_if_i),
        .stallreq_id_i     (stallreq_id_i),
        .stallreq_ex_i     (stallreq_ex_i),
        .stallreq_mem_i    (stallreq_mem_i),
        .branch_redirect_i (branch_redirect_i),
        .branch_target_i   (branch_target_i),
        .exception_i       (exception_i),
        .exception_pc_i    (exception_pc_i),
        .exception_inst_i  (exception_inst_i),
        .mtvec_i           (mtvec_i),
        .mepc_i            (mepc_i),
        .stall_o           (stall_o),
        .flush_o           (flush_o),
        .branch_kill_o     (branch_kill_o),
        .redirect_o        (redirect_o),
        .new_pc_o          (new_pc_o),
        .trap_we_o         (trap_we_o),
        .trap_cause_o      (trap_cause_o),
        .trap_epc_o        (trap_epc_o),
        .trap_tval_o       (trap_tval_o),
        .mret_o            (mret_o)
`ifdef PIPE_CTRL_PERF_CNT_EN
        ,
        .perf_stall_cnt_o  (perf_stall_cnt_o),
        .perf_trap_cnt_o   (perf_trap_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 2 time units past the edge.
    task automatic cyc();
        @(posedge clk_i);
        #2;
    endtask

    task automatic clr();
        stallreq_if_i = 0; stallreq_id_i = 0; stallreq_ex_i = 0; stallreq_mem_i = 0;
        branch_redirect_i = 0; branch_target_i = 0;
        exception_i = 0; exception_pc_i = 0; exception_inst_i = 0;
    endtask

    // Full output picture of a trap fire cycle.
    task automatic chk_fire(input string tag, input logic [31:0] pc, input logic [31:0] cause,
                            input logic [31:0] epc, input logic [31:0] tval);
        chk({tag, ".flush"}, {31'd0, flush_o}, 32'd1);
        chk({tag, ".redir"}, {31'd0, redirect_o}, 32'd1);
        chk({tag, ".stall"}, {26'd0, stall_o}, 32'd0);
        chk({tag, ".we"}, {31'd0, trap_we_o}, 32'd1);
        chk({tag, ".mret"}, {31'd0, mret_o}, 32'd0);
        chk({tag, ".pc"}, new_pc_o, pc);
        chk({tag, ".cause"}, trap_cause_o, cause);
        chk({tag, ".epc"}, trap_epc_o, epc);
        chk({tag, ".tval"}, trap_tval_o, tval);
    endtask

    initial begin
        clr();
        mtvec_i = 32'h105; mepc_i = 32'h0;
        n_rst_i = 0;
        #3;
        chk("rst.stall", {26'd0, stall_o}, 32'd0);
        chk("rst.ctl", {27'd0, flush_o, branch_kill_o, redirect_o, trap_we_o, mret_o}, 32'd0);
        chk("rst.pc", new_pc_o, 32'h0);
        #5 n_rst_i = 1;
        cyc();

        // Stall merge
        stallreq_id_i = 1; #1;
        chk("id.stall", {26'd0, stall_o}, 32'h07);
        stallreq_mem_i = 1; #1;
        chk("mem.stall", {26'd0, stall_o}, 32'h1F);
        chk("mem.flush", {31'd0, flush_o}, 32'd0);
        stallreq_mem_i = 0; stallreq_id_i = 0; stallreq_ex_i = 1; #1;
        chk("ex.stall", {26'd0, stall_o}, 32'h0F);
        stallreq_ex_i = 0; stallreq_if_i = 1; #1;
        chk("if.stall", {26'd0, stall_o}, 32'h03);
        clr(); #1;

        // Illegal instruction trap; stalls/branch during hold are ignored
        exception_i = 32'h2; exception_pc_i = 32'h80; exception_inst_i = 32'hFFFF_FFFF; #1;
        chk("ill.det.stall", {26'd0, stall_o}, 32'd0);
        chk("ill.det.redir", {31'd0, redirect_o}, 32'd0);
        cyc(); clr();
        stallreq_id_i = 1; branch_redirect_i = 1; branch_target_i = 32'h999; #1;
        chk("ill.hold.stall", {26'd0, stall_o}, 32'h1F);
        chk("ill.hold.redir", {31'd0, redirect_o}, 32'd0);
        chk("ill.hold.flush", {31'd0, flush_o}, 32'd0);
        cyc(); clr(); #1;
        chk_fire("ill.fire", 32'h104, 32'd2, 32'h80, 32'hFFFF_FFFF);
        cyc(); #1;
        chk("ill.after.flush", {31'd0, flush_o}, 32'd0);
        chk("ill.after.we", {31'd0, trap_we_o}, 32'd0);

        // ecall held off by a busy mem stage for 3 cycles
        exception_i = 32'h20; exception_pc_i = 32'h120; stallreq_mem_i = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("ecall.wait%0d.flush", i), {31'd0, flush_o}, 32'd0);
            chk($sformatf("ecall.wait%0d.stall", i), {26'd0, stall_o}, 32'h1F);
            cyc();
        end
        stallreq_mem_i = 0; #1;
        chk("ecall.det.stall", {26'd0, stall_o}, 32'd0);
        cyc(); clr(); #1;
        chk("ecall.hold.stall", {26'd0, stall_o}, 32'h1F);
        cyc(); #1;
        chk_fire("ecall.fire", 32'h104, 32'd11, 32'h120, 32'd0);
        cyc();

        // Branch redirect
        branch_redirect_i = 1; branch_target_i = 32'h200; #1;
        chk("br.redir", {31'd0, redirect_o}, 32'd1);
        chk("br.kill", {31'd0, branch_kill_o}, 32'd1);
        chk("br.pc", new_pc_o, 32'h200);
        chk("br.stall", {26'd0, stall_o}, 32'd0);
        stallreq_id_i = 1; #1;
        chk("br.id.stall", {26'd0, stall_o}, 32'h05);
        chk("br.id.redir", {31'd0, redirect_o}, 32'd1);
        stallreq_id_i = 0; stallreq_if_i = 1; #1;
        chk("br.if.stall", {26'd0, stall_o}, 32'h01);
        stallreq_if_i = 0; stallreq_ex_i = 1; #1;
        chk("br.ex.redir", {31'd0, redirect_o}, 32'd0);
        chk("br.ex.kill", {31'd0, branch_kill_o}, 32'd0);
        chk("br.ex.stall", {26'd0, stall_o}, 32'h0F);
        stallreq_ex_i = 0; stallreq_mem_i = 1; #1;
        chk("br.mem.redir", {31'd0, redirect_o}, 32'd0);
        clr(); cyc();

        // Branch and load-misaligned together: exception wins
        branch_redirect_i = 1; branch_target_i = 32'h200;
        exception_i = 32'h8; exception_pc_i = 32'h300; exception_inst_i = 32'h1234; #1;
        chk("brexc.redir", {31'd0, redirect_o}, 32'd0);
        chk("brexc.kill", {31'd0, branch_kill_o}, 32'd0);
        cyc(); clr(); cyc(); #1;
        chk_fire("lma.fire", 32'h104, 32'd4, 32'h300, 32'h300);
        cyc();

        // Multiple bits: illegal (bit1) beats store-misaligned (bit4)
        exception_i = 32'h12; exception_pc_i = 32'h40; exception_inst_i = 32'hABCD; #1;
        cyc(); clr(); cyc(); #1;
        chk_fire("multi.fire", 32'h104, 32'd2, 32'h40, 32'hABCD);
        cyc();

        // mret
        mepc_i = 32'h44; exception_i = 32'h40; exception_pc_i = 32'h60; #1;
        cyc(); clr(); cyc(); #1;
        chk("mret.mret", {31'd0, mret_o}, 32'd1);
        chk("mret.pc", new_pc_o, 32'h44);
        chk("mret.we", {31'd0, trap_we_o}, 32'd0);
        chk("mret.flush", {31'd0, flush_o}, 32'd1);
        cyc();

        // Reset during hold aborts the trap
        exception_i = 32'h1; exception_pc_i = 32'h88; #1;
        cyc(); clr(); #1;
        chk("rsth.pre.stall", {26'd0, stall_o}, 32'h1F);
        n_rst_i = 0; #1;
        chk("rsth.stall", {26'd0, stall_o}, 32'd0);
        chk("rsth.ctl", {27'd0, flush_o, branch_kill_o, redirect_o, trap_we_o, mret_o}, 32'd0);
        #3 n_rst_i = 1;
        cyc(); #1;
        chk("rsth.nofire.flush", {31'd0, flush_o}, 32'd0);
        chk("rsth.nofire.we", {31'd0, trap_we_o}, 32'd0);
        chk("rsth.nofire.stall", {26'd0, stall_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
